// File: rtl/vreg_wb_arbiter_pkg.sv
// rtl/vreg_wb_arbiter_pkg.sv - shared types and constants for the vreg write-back arbiter
package vreg_wb_arbiter_pkg;

  typedef enum logic {
    VREG_WB_SRC_ARITH  = 1'b0,
    VREG_WB_SRC_MEMORY = 1'b1
  } vreg_wb_src_t;

  typedef struct packed {
    logic [4:0]   addr;
    logic [127:0] data;
    logic [1:0]   etw;
  } vreg_wb_entry_t;

  localparam int unsigned VREG_WB_MAX_WAIT = 4;

  function automatic logic vreg_wb_addr_hit(logic valid, logic [4:0] addr, logic [4:0] probe);
    return valid && (addr == probe);
  endfunction

endpackage

// File: rtl/vreg_wb_arbiter_if.sv
// rtl/vreg_wb_arbiter_if.sv - arith/VLSU sources, vreg write port and hazard probe
interface vreg_wb_arbiter_if;
  import vreg_wb_arbiter_pkg::*;

  logic         arith_valid_i;
  logic         arith_ready_o;
  logic [4:0]   arith_addr_i;
  logic [127:0] arith_data_i;
  logic [1:0]   arith_etw_i;

  logic         lsu_req_i;
  logic         lsu_gnt_o;
  logic [4:0]   lsu_addr_i;
  logic [127:0] lsu_data_i;
  logic [1:0]   lsu_etw_i;

  logic         vreg_we_o;
  logic [4:0]   vreg_addr_o;
  logic [127:0] vreg_data_o;
  logic [1:0]   vreg_etw_o;
  vreg_wb_src_t vreg_src_o;

  logic [4:0]   hazard_addr_i;
  logic         hazard_o;
  logic         busy_o;

  modport slave (
    input  arith_valid_i, arith_addr_i, arith_data_i, arith_etw_i,
    output arith_ready_o,
    input  lsu_req_i, lsu_addr_i, lsu_data_i, lsu_etw_i,
    output lsu_gnt_o,
    output vreg_we_o, vreg_addr_o, vreg_data_o, vreg_etw_o, vreg_src_o,
    input  hazard_addr_i,
    output hazard_o, busy_o
  );

  modport master (
    output arith_valid_i, arith_addr_i, arith_data_i, arith_etw_i,
    input  arith_ready_o,
    output lsu_req_i, lsu_addr_i, lsu_data_i, lsu_etw_i,
    input  lsu_gnt_o,
    input  vreg_we_o, vreg_addr_o, vreg_data_o, vreg_etw_o, vreg_src_o,
    output hazard_addr_i,
    input  hazard_o, busy_o
  );

endinterface

// File: rtl/vreg_wb_arbiter_fifo.sv
// rtl/vreg_wb_arbiter_fifo.sv - 2-entry FIFO of pending arithmetic results
module vreg_wb_arbiter_fifo
  import vreg_wb_arbiter_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic                push_i,
  input  vreg_wb_entry_t      push_entry_i,
  input  logic                pop_i,
  output vreg_wb_entry_t      head_o,
  output logic                full_o,
  output logic                empty_o,
  output logic [1:0]          valid_o,
  output logic [1:0][4:0]     addr_o
);

  vreg_wb_entry_t mem_q [2];
  logic           rd_ptr_q, rd_ptr_d;
  logic           wr_ptr_q, wr_ptr_d;
  logic [1:0]     count_q, count_d;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = ~wr_ptr_q;
    if (pop_i)  rd_ptr_d = ~rd_ptr_q;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_entry_i;
  end

  assign full_o     = (count_q == 2'd2);
  assign empty_o    = (count_q == 2'd0);
  assign head_o     = mem_q[rd_ptr_q];
  assign valid_o[0] = full_o || ((count_q == 2'd1) && !rd_ptr_q);
  assign valid_o[1] = full_o || ((count_q == 2'd1) && rd_ptr_q);
  assign addr_o[0]  = mem_q[0].addr;
  assign addr_o[1]  = mem_q[1].addr;

endmodule

// File: rtl/vreg_wb_arbiter.sv
// rtl/vreg_wb_arbiter.sv - shares the vreg write port between arith results and the VLSU
module vreg_wb_arbiter
  import vreg_wb_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = VREG_WB_MAX_WAIT
) (
  input logic              clk,
  input logic              reset,
  vreg_wb_arbiter_if.slave bus
);

  localparam int unsigned       WAIT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  vreg_wb_entry_t    fifo_head;
  vreg_wb_entry_t    push_entry;
  logic              fifo_full, fifo_empty;
  logic [1:0]        fifo_valid;
  logic [1:0][4:0]   fifo_addr;
  logic              push, pop, gnt, force_arith;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;

  logic              vreg_we_q, vreg_we_d;
  logic [4:0]        vreg_addr_q, vreg_addr_d;
  logic [127:0]      vreg_data_q, vreg_data_d;
  logic [1:0]        vreg_etw_q, vreg_etw_d;
  vreg_wb_src_t      vreg_src_q, vreg_src_d;

  assign push_entry = '{addr: bus.arith_addr_i, data: bus.arith_data_i, etw: bus.arith_etw_i};

  vreg_wb_arbiter_fifo u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (fifo_head),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .valid_o      (fifo_valid),
    .addr_o       (fifo_addr)
  );

  assign bus.arith_ready_o = !reset && !fifo_full;
  assign push              = bus.arith_valid_i && bus.arith_ready_o;

  // A head that has lost MAX_WAIT times in a row takes the port regardless of the VLSU.
  assign force_arith   = !fifo_empty && (wait_cnt_q == WAIT_MAX);
  assign gnt           = !reset && bus.lsu_req_i && !force_arith;
  assign pop           = !reset && !fifo_empty && !gnt;
  assign bus.lsu_gnt_o = gnt;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (fifo_empty || pop) begin
      wait_cnt_d = '0;
    end else if (gnt && (wait_cnt_q != WAIT_MAX)) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  always_comb begin
    vreg_we_d   = 1'b0;
    vreg_addr_d = vreg_addr_q;
    vreg_data_d = vreg_data_q;
    vreg_etw_d  = vreg_etw_q;
    vreg_src_d  = vreg_src_q;
    if (pop) begin
      vreg_we_d   = 1'b1;
      vreg_addr_d = fifo_head.addr;
      vreg_data_d = fifo_head.data;
      vreg_etw_d  = fifo_head.etw;
      vreg_src_d  = VREG_WB_SRC_ARITH;
    end else if (gnt) begin
      vreg_we_d   = 1'b1;
      vreg_addr_d = bus.lsu_addr_i;
      vreg_data_d = bus.lsu_data_i;
      vreg_etw_d  = bus.lsu_etw_i;
      vreg_src_d  = VREG_WB_SRC_MEMORY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt_q  <= '0;
      vreg_we_q   <= 1'b0;
      vreg_addr_q <= '0;
      vreg_data_q <= '0;
      vreg_etw_q  <= '0;
      vreg_src_q  <= VREG_WB_SRC_ARITH;
    end else begin
      wait_cnt_q  <= wait_cnt_d;
      vreg_we_q   <= vreg_we_d;
      vreg_addr_q <= vreg_addr_d;
      vreg_data_q <= vreg_data_d;
      vreg_etw_q  <= vreg_etw_d;
      vreg_src_q  <= vreg_src_d;
    end
  end

  assign bus.vreg_we_o   = vreg_we_q;
  assign bus.vreg_addr_o = vreg_addr_q;
  assign bus.vreg_data_o = vreg_data_q;
  assign bus.vreg_etw_o  = vreg_etw_q;
  assign bus.vreg_src_o  = vreg_src_q;

  assign bus.hazard_o = !reset && (
      vreg_wb_addr_hit(fifo_valid[0], fifo_addr[0], bus.hazard_addr_i) ||
      vreg_wb_addr_hit(fifo_valid[1], fifo_addr[1], bus.hazard_addr_i) ||
      vreg_wb_addr_hit(bus.lsu_req_i, bus.lsu_addr_i, bus.hazard_addr_i) ||
      vreg_wb_addr_hit(vreg_we_q, vreg_addr_q, bus.hazard_addr_i));

  assign bus.busy_o = !reset && (!fifo_empty || bus.lsu_req_i || vreg_we_q);

endmodule
